// File: rtl/lc3_pipeline_dmem_if.sv
// Memory-stage bus between the LC-3 pipeline (master) and its data-memory responder (slave).
// One request in flight at a time; the master holds the request until mem_ready.
interface lc3_pipeline_dmem_if;
    logic        memapply;
    logic [15:0] memaddr;
    logic        memwrite;
    logic [15:0] memwdata;
    logic [15:0] memdata;
    logic        mem_ready;
    logic        stall_req;
    logic        mem_err;

    modport master (
        output memapply, memaddr, memwrite, memwdata,
        input  memdata, mem_ready, stall_req, mem_err
    );

    modport slave (
        input  memapply, memaddr, memwrite, memwdata,
        output memdata, mem_ready, stall_req, mem_err
    );
endinterface

// File: rtl/lc3_pipeline_dmem.sv
// LC-3 data-memory responder: word-addressed on-chip array behind a fixed wait-state
// IDLE -> WAIT -> RESP sequencer that freezes the pipeline while an access is pending.
module lc3_pipeline_dmem #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    lc3_pipeline_dmem_if.slave bus
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        write_q;

    logic [15:0] mem [DEPTH];

    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_write;
    logic        acc_oor;
    logic        enter_resp;

    logic [15:0] memdata_q;
    logic        ready_q;
    logic        err_q;

    // With zero wait states the array is touched on the accept edge itself, before the
    // request registers have loaded, so the access takes the live bus values in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr  = bus.memaddr;
            acc_wdata = bus.memwdata;
            acc_write = bus.memwrite;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = write_q;
        end
    end

    assign acc_oor    = (acc_addr >> ADDR_W) != 16'h0000;
    assign enter_resp = (state_d == ST_RESP);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.memapply) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            write_q   <= 1'b0;
            memdata_q <= 16'h0000;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.memapply) begin
                addr_q  <= bus.memaddr;
                wdata_q <= bus.memwdata;
                write_q <= bus.memwrite;
            end
            ready_q <= enter_resp;
            err_q   <= enter_resp && acc_oor;
            if (enter_resp && !acc_write) begin
                memdata_q <= acc_oor ? 16'h0000 : mem[acc_addr[ADDR_W-1:0]];
            end
        end
    end

    // NOTE: the array has no reset; gating with reset keeps an access that would complete
    // while reset is held from corrupting the contents.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_write && !acc_oor) begin
            mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
        end
    end

    assign bus.memdata   = memdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.stall_req = ((state_q == ST_IDLE) && bus.memapply) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_lc3_pipeline_dmem.sv
// Directed bench for lc3_pipeline_dmem: one instance with WAIT=2 and one with WAIT=0,
// both ADDR_W=10, sharing clock and reset.
module tb_lc3_pipeline_dmem;

    localparam bit D2 = 1'b0;
    localparam bit D0 = 1'b1;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_pipeline_dmem_if bus2 ();
    lc3_pipeline_dmem_if bus0 ();

    lc3_pipeline_dmem #(.ADDR_W(10), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    lc3_pipeline_dmem #(.ADDR_W(10), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit sel, input logic app, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (sel == D0) begin
            bus0.memapply = app; bus0.memwrite = wr; bus0.memaddr = addr; bus0.memwdata = wdata;
        end else begin
            bus2.memapply = app; bus2.memwrite = wr; bus2.memaddr = addr; bus2.memwdata = wdata;
        end
    endtask

    function automatic logic ready_of(input bit sel);
        return (sel == D0) ? bus0.mem_ready : bus2.mem_ready;
    endfunction

    function automatic logic stall_of(input bit sel);
        return (sel == D0) ? bus0.stall_req : bus2.stall_req;
    endfunction

    function automatic logic [15:0] data_of(input bit sel);
        return (sel == D0) ? bus0.memdata : bus2.memdata;
    endfunction

    function automatic logic err_of(input bit sel);
        return (sel == D0) ? bus0.mem_err : bus2.mem_err;
    endfunction

    // One complete access; reports data/err seen in RESP, stall cycles and the cycle of mem_ready.
    task automatic access(input bit sel, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output logic err, output int stalls, output int ready_at);
        int exp_lat;
        exp_lat  = (sel == D0) ? 2 : 4;
        stalls   = 0;
        ready_at = 0;
        rdata    = 16'hxxxx;
        err      = 1'bx;
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, addr, wdata);
        for (int c = 1; c <= 20 && ready_at == 0; c++) begin
            @(negedge clk);
            if (stall_of(sel)) stalls++;
            if (ready_of(sel)) begin
                ready_at = c;
                rdata    = data_of(sel);
                err      = err_of(sel);
                check("stall_low_in_resp", stall_of(sel), 1'b0);
            end
        end
        check("ready_latency", ready_at, exp_lat);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("ready_single_pulse", ready_of(sel), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          st, rat, pulses, got_at;
        logic [15:0] got_data;
        logic        exp_ready [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        exp_stall [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] exp_data  [4] = '{16'h0000, 16'h1111, 16'h1111, 16'h2222};

        // Reset state
        reset = 1'b0;
        drive(D2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(D0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_memdata", bus2.memdata, 16'h0000);
        check("rst_ready", bus2.mem_ready, 1'b0);
        check("rst_err", bus2.mem_err, 1'b0);
        check("rst_stall", bus2.stall_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_memdata", bus2.memdata, 16'h0000);
        check("post_rst_ready", bus0.mem_ready, 1'b0);
        check("post_rst_stall", bus0.stall_req, 1'b0);

        // Write then read, WAIT=2
        access(D2, 1'b1, 16'h0012, 16'hBEEF, rd, er, st, rat);
        check("wr_stall_cycles", st, 3);
        check("wr_err", er, 1'b0);
        check("wr_memdata_unchanged", rd, 16'h0000);
        access(D2, 1'b0, 16'h0012, 16'h0000, rd, er, st, rat);
        check("rd_beef", rd, 16'hBEEF);
        check("rd_stall_cycles", st, 3);
        access(D2, 1'b1, 16'h0013, 16'h7777, rd, er, st, rat);
        check("wr_keeps_memdata", rd, 16'hBEEF);

        // WAIT=0: preload, then back-to-back reads with memapply held high
        access(D0, 1'b1, 16'h0001, 16'h1111, rd, er, st, rat);
        check("w0_stall_cycles", st, 1);
        access(D0, 1'b1, 16'h0002, 16'h2222, rd, er, st, rat);
        @(posedge clk); #1;
        drive(D0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_%0d", c), bus0.mem_ready, exp_ready[c]);
            check($sformatf("b2b_stall_%0d", c), bus0.stall_req, exp_stall[c]);
            check($sformatf("b2b_data_%0d", c), bus0.memdata, exp_data[c]);
            if (c == 1) bus0.memaddr = 16'h0002;
        end
        bus0.memapply = 1'b0;
        @(negedge clk);
        check("b2b_idle_ready", bus0.mem_ready, 1'b0);
        check("b2b_idle_stall", bus0.stall_req, 1'b0);

        // Out of range, ADDR_W=10
        access(D2, 1'b1, 16'h0000, 16'h0A0A, rd, er, st, rat);
        access(D2, 1'b1, 16'h0400, 16'h5555, rd, er, st, rat);
        check("oor_wr_err", er, 1'b1);
        access(D2, 1'b0, 16'h0000, 16'h0000, rd, er, st, rat);
        check("addr0_unchanged", rd, 16'h0A0A);
        check("addr0_err", er, 1'b0);
        access(D2, 1'b0, 16'h8000, 16'h0000, rd, er, st, rat);
        check("oor_rd_data", rd, 16'h0000);
        check("oor_rd_err", er, 1'b1);
        access(D2, 1'b1, 16'h03FF, 16'h3FF3, rd, er, st, rat);
        check("top_wr_err", er, 1'b0);
        access(D2, 1'b0, 16'h03FF, 16'h0000, rd, er, st, rat);
        check("top_rd_data", rd, 16'h3FF3);

        // Reset during the WAIT phase of a write
        access(D2, 1'b1, 16'h0005, 16'h1234, rd, er, st, rat);
        @(posedge clk); #1;
        drive(D2, 1'b1, 1'b1, 16'h0005, 16'hAAAA);
        @(negedge clk);
        check("midrst_accept_stall", bus2.stall_req, 1'b1);
        @(negedge clk);
        check("midrst_wait_stall", bus2.stall_req, 1'b1);
        reset = 1'b0;
        drive(D2, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("midrst_ready", bus2.mem_ready, 1'b0);
        check("midrst_stall", bus2.stall_req, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus2.mem_ready) pulses++;
        end
        check("midrst_no_ready", pulses, 0);
        access(D2, 1'b0, 16'h0005, 16'h0000, rd, er, st, rat);
        check("midrst_old_value", rd, 16'h1234);

        // Protocol violation: memapply dropped and address changed during WAIT
        @(posedge clk); #1;
        drive(D2, 1'b1, 1'b0, 16'h0012, 16'h0000);
        pulses   = 0;
        got_at   = 0;
        got_data = 16'h0000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus2.mem_ready) begin
                pulses++;
                got_at   = c;
                got_data = bus2.memdata;
            end
            if (c == 2) drive(D2, 1'b0, 1'b0, 16'h0013, 16'h0000);
        end
        check("viol_pulses", pulses, 1);
        check("viol_ready_cycle", got_at, 4);
        check("viol_data", got_data, 16'hBEEF);
        check("viol_idle_stall", bus2.stall_req, 1'b0);
        access(D2, 1'b0, 16'h0013, 16'h0000, rd, er, st, rat);
        check("viol_next_access", rd, 16'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
